// File: rtl/seq_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider_pkg
//  Purpose  : Shared state encoding and sign helper for the sequential divider
//  Revision : 1.0  initial release
// ============================================================================
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Widest operand the sign helper supports; callers truncate the result.
    localparam int c_max_width = 64;

    function automatic logic [c_max_width-1:0] neg_if(
        input logic                   en,
        input logic [c_max_width-1:0] v
    );
        return en ? (~v + {{(c_max_width-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider_step.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider_step
//  Purpose  : One combinational restoring-division step (shift, trial subtract)
//  Revision : 1.0  initial release
// ============================================================================
module seq_divider_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    // rem_in < divisor always holds, so the trial difference lies in
    // [-divisor, divisor) and its top bit is exactly the borrow.
    always_comb begin
        w_shift = {rem_in, dvd_bit};
        w_diff  = w_shift - {1'b0, divisor};
        q_bit   = ~w_diff[WIDTH];
        rem_out = q_bit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider
//  Purpose  : Iterative restoring divider, STEPS quotient bits per clock,
//             signed/unsigned, divide-by-zero and overflow flags, handshakes
//  Revision : 1.0  initial release
// ============================================================================
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEPS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int             c_n     = WIDTH / STEPS;
    localparam int             c_cnt_w = $clog2(c_n) + 1;
    localparam logic [WIDTH-1:0] c_min = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             r_state;
    state_t             w_state_nxt;
    state_t             w_start_state;

    logic [WIDTH-1:0]   r_dvd;      // |dividend| shifting out, quotient shifting in
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_rem;
    logic               r_dvd_neg;
    logic               r_dvs_neg;
    logic               r_dbz;
    logic               r_ovf;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_accept;
    logic               w_dvd_neg;
    logic               w_dvs_neg;
    logic [WIDTH-1:0]   w_dvd_abs;
    logic [WIDTH-1:0]   w_dvs_abs;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_dvd_shift;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_dvd_fix;

    logic [WIDTH-1:0]   w_rem [0:STEPS];
    logic [STEPS-1:0]   w_qbits;

    // ------------------------------------------------------------------
    // Handshake and operand preparation
    // ------------------------------------------------------------------
    assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign out_valid = (r_state == DONE);
    assign w_accept  = in_valid && in_ready;

    assign w_dvd_neg = is_signed && Dividend[WIDTH-1];
    assign w_dvs_neg = is_signed && Divisor[WIDTH-1];
    assign w_dvd_abs = WIDTH'(neg_if(w_dvd_neg, c_max_width'(Dividend)));
    assign w_dvs_abs = WIDTH'(neg_if(w_dvs_neg, c_max_width'(Divisor)));
    assign w_ovf     = is_signed && (Dividend == c_min) && (&Divisor);

    assign w_start_state = (Divisor == '0) ? FIX : CALC;

    // ------------------------------------------------------------------
    // Step chain: stage k consumes the k-th dividend bit from the MSB
    // ------------------------------------------------------------------
    assign w_rem[0] = r_rem;

    generate
        for (genvar k = 0; k < STEPS; k++) begin : g_step
            seq_divider_step #(
                .WIDTH(WIDTH)
            ) u_step (
                .rem_in (w_rem[k]),
                .dvd_bit(r_dvd[WIDTH-1-k]),
                .divisor(r_dvs),
                .rem_out(w_rem[k+1]),
                .q_bit  (w_qbits[STEPS-1-k])
            );
        end
    endgenerate

    assign w_dvd_shift = (r_dvd << STEPS) | WIDTH'(w_qbits);

    // ------------------------------------------------------------------
    // Sign fix-up; on divide-by-zero r_dvd is untouched so re-negating it
    // reproduces the original dividend.
    // ------------------------------------------------------------------
    assign w_dvd_fix = WIDTH'(neg_if(r_dvd_neg, c_max_width'(r_dvd)));
    assign w_quo_fix = r_dbz ? '1
                             : WIDTH'(neg_if(r_dvd_neg ^ r_dvs_neg, c_max_width'(r_dvd)));
    assign w_rem_fix = r_dbz ? w_dvd_fix
                             : WIDTH'(neg_if(r_dvd_neg, c_max_width'(r_rem)));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = w_start_state;
            CALC: if (r_cnt == c_cnt_w'(1)) w_state_nxt = FIX;
            FIX:  w_state_nxt = DONE;
            DONE: begin
                if (out_ready) w_state_nxt = w_accept ? w_start_state : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_dvd_neg   <= 1'b0;
            r_dvs_neg   <= 1'b0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
            r_cnt       <= '0;
            Quotient    <= '0;
            Remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_accept) begin
                r_dvd     <= w_dvd_abs;
                r_dvs     <= w_dvs_abs;
                r_rem     <= '0;
                r_dvd_neg <= w_dvd_neg;
                r_dvs_neg <= w_dvs_neg;
                r_dbz     <= (Divisor == '0);
                r_ovf     <= w_ovf;
                r_cnt     <= c_cnt_w'(c_n);
            end else if (r_state == CALC) begin
                r_dvd <= w_dvd_shift;
                r_rem <= w_rem[STEPS];
                r_cnt <= r_cnt - c_cnt_w'(1);
            end

            if (r_state == FIX) begin
                Quotient    <= w_quo_fix;
                Remainder   <= w_rem_fix;
                div_by_zero <= r_dbz;
                overflow    <= r_ovf;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_divider
//  Purpose  : Directed vector table, handshake corner sequences and a random
//             16-bit/4-step run against a behavioural division model
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        reset;

    logic        in_valid, in_ready, is_signed, out_valid, out_ready;
    logic [31:0] dvd, dvs, quo, rem;
    logic        dbz, ovf;

    logic        iv16, ir16, sg16, ov16, or16, z16, f16;
    logic [15:0] a16, b16, q16, r16;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(32), .STEPS(1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .is_signed(is_signed),
        .Dividend(dvd), .Divisor(dvs),
        .out_valid(out_valid), .out_ready(out_ready),
        .Quotient(quo), .Remainder(rem),
        .div_by_zero(dbz), .overflow(ovf)
    );

    seq_divider #(.WIDTH(16), .STEPS(4)) dut16 (
        .clk(clk), .reset(reset),
        .in_valid(iv16), .in_ready(ir16), .is_signed(sg16),
        .Dividend(a16), .Divisor(b16),
        .out_valid(ov16), .out_ready(or16),
        .Quotient(q16), .Remainder(r16),
        .div_by_zero(z16), .overflow(f16)
    );

    typedef struct {
        string       name;
        logic        s;
        logic [31:0] a, b, q, r;
        logic        z, o;
        int          lat;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input string n, input logic s, input logic [31:0] a, b, q, r,
                       input logic z, o, input int lat);
        vec_t v;
        v.name = n; v.s = s; v.a = a; v.b = b; v.q = q; v.r = r;
        v.z = z; v.o = o; v.lat = lat;
        vq.push_back(v);
    endtask

    task automatic start32(input logic s, input logic [31:0] a, b);
        int g = 0;
        @(negedge clk);
        is_signed = s; dvd = a; dvs = b; in_valid = 1'b1;
        while (!in_ready && g < 100) begin @(negedge clk); g++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait32(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic consume32;
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic model16(input logic s, input logic [15:0] a, b,
                           output logic [15:0] q, r, output logic z, o);
        z = 1'b0; o = 1'b0;
        if (b == 16'd0) begin
            q = 16'hFFFF; r = a; z = 1'b1;
        end else if (s && a == 16'h8000 && b == 16'hFFFF) begin
            q = 16'h8000; r = 16'h0; o = 1'b1;
        end else if (s) begin
            q = 16'($signed(a) / $signed(b));
            r = 16'($signed(a) % $signed(b));
        end else begin
            q = a / b; r = a % b;
        end
    endtask

    task automatic run16(input logic s, input logic [15:0] a, b);
        int g = 0;
        int lat = 0;
        logic [15:0] eq, er;
        logic ez, eo;
        model16(s, a, b, eq, er, ez, eo);
        @(negedge clk);
        sg16 = s; a16 = a; b16 = b; iv16 = 1'b1;
        while (!ir16 && g < 100) begin @(negedge clk); g++; end
        @(posedge clk); #1;
        iv16 = 1'b0;
        while (!ov16 && lat < 50) begin @(posedge clk); #1; lat++; end
        chk($sformatf("r16 %0d:%h/%h res", s, a, b), {q16, r16, z16, f16}, {eq, er, ez, eo});
        chk($sformatf("r16 %0d:%h/%h lat", s, a, b), 64'(lat), (b == 16'd0) ? 64'd1 : 64'd5);
        @(negedge clk); or16 = 1'b1;
        @(posedge clk); #1; or16 = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   lat;
        logic seen;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; is_signed = 1'b0;
        dvd = '0; dvs = '0;
        iv16 = 1'b0; or16 = 1'b0; sg16 = 1'b0; a16 = '0; b16 = '0;

        add("u100/7",      0, 32'd100,       32'd7,         32'd14,        32'd2,         0, 0, 33);
        add("s-7/2",       1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  0, 0, 33);
        add("uFFF9/2",     0, 32'hFFFFFFF9,  32'd2,         32'h7FFFFFFC,  32'd1,         0, 0, 33);
        add("u5/0",        0, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         1, 0, 1);
        add("sMIN/0",      1, 32'h80000000,  32'd0,         32'hFFFFFFFF,  32'h80000000,  1, 0, 1);
        add("sMIN/-1",     1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         0, 1, 33);
        add("uMAX/1",      0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0,         0, 0, 33);
        add("s7/-2",       1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         0, 0, 33);
        add("s-7/-2",      1, 32'hFFFFFFF9,  32'hFFFFFFFE,  32'd3,         32'hFFFFFFFF,  0, 0, 33);
        add("u3/10",       0, 32'd3,         32'd10,        32'd0,         32'd3,         0, 0, 33);
        add("uMIN/MAX",    0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  0, 0, 33);

        repeat (3) @(posedge clk);
        #1;
        chk("reset outs", {in_ready, out_valid, quo, rem, dbz, ovf}, {1'b1, 1'b0, 64'd0, 2'b00});
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        chk("post-reset in_ready", in_ready, 1'b1);

        for (int i = 0; i < vq.size(); i++) begin
            start32(vq[i].s, vq[i].a, vq[i].b);
            wait32(lat);
            chk($sformatf("%s Q", vq[i].name), quo, vq[i].q);
            chk($sformatf("%s R", vq[i].name), rem, vq[i].r);
            chk($sformatf("%s flags", vq[i].name), {dbz, ovf}, {vq[i].z, vq[i].o});
            chk($sformatf("%s lat", vq[i].name), 64'(lat), 64'(vq[i].lat));
            consume32;
            chk($sformatf("%s consumed", vq[i].name), out_valid, 1'b0);
        end

        // Backpressure: hold result, then release with a new op pending.
        start32(0, 32'd100, 32'd7);
        wait32(lat);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk($sformatf("hold %0d", c), {in_ready, out_valid, quo, rem}, {1'b0, 1'b1, 32'd14, 32'd2});
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; is_signed = 1'b0; dvd = 32'd50; dvs = 32'd5;
        #1;
        chk("b2b in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        chk("b2b accepted", {out_valid, in_ready}, 2'b00);
        wait32(lat);
        chk("b2b result", {quo, rem}, {32'd10, 32'd0});
        chk("b2b lat", 64'(lat), 64'd33);
        consume32;

        // Reset during CALC aborts the op.
        start32(0, 32'd1000, 32'd3);
        repeat (11) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        chk("abort in_ready", {in_ready, out_valid}, 2'b10);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("abort no result", seen, 1'b0);

        // 16-bit, 4 steps/clock: specials then random.
        run16(1, 16'h8000, 16'hFFFF);
        run16(1, 16'hFFF9, 16'h0002);
        run16(0, 16'h1234, 16'h0000);
        run16(0, 16'hFFFF, 16'h0001);
        for (int i = 0; i < 300; i++) begin
            logic        s;
            logic [15:0] a, b;
            int          sel;
            s   = 1'($urandom_range(0, 1));
            a   = 16'($urandom);
            sel = $urandom_range(0, 9);
            if ($urandom_range(0, 9) == 0) a = 16'h8000;
            case (sel)
                0:       b = 16'h0000;
                1:       b = 16'hFFFF;
                2:       b = 16'($urandom_range(1, 15));
                default: b = 16'($urandom);
            endcase
            run16(s, a, b);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
